// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between the IF-stage fetch port and the
// MEM-stage load/store port. One access is in flight at a time. Each access
// holds the memory interface for MEM_LAT cycles. Data requests take priority,
// and a streak counter forces a fetch grant after STREAK_MAX consecutive data
// grants that were made while a fetch was waiting.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STREAK_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  // The counter width must hold MEM_LAT, and the streak width must hold STREAK_MAX.
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STREAK_MAX + 1);

  localparam logic [CW-1:0] LAT_INIT   = CW'(MEM_LAT);
  localparam logic [CW-1:0] LAT_LAST   = CW'(1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(STREAK_MAX);

  // Current state.
  state_t          state_q;
  owner_t          owner_q;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   streak_q;
  logic            killed_q;

  // Next state.
  state_t          state_d;
  owner_t          owner_d;
  logic [CW-1:0]   cnt_d;
  logic [SW-1:0]   streak_d;
  logic            killed_d;
  logic            mem_en_d;
  logic            mem_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d;
  logic            if_ready_d;
  logic            dm_ready_d;
  logic [DW-1:0]   if_rdata_d;
  logic [DW-1:0]   dm_rdata_d;

  // Arbitration terms.
  logic            fetch_elig;
  logic            data_elig;
  logic            streak_at_cap;
  logic            grant_data;
  logic            grant_fetch;
  logic            fetch_dead;

  // A halted core or a flushed pipeline must not start a fetch.
  assign fetch_elig    = if_req & ~halt & ~flush;
  assign data_elig     = dm_req;
  assign streak_at_cap = (streak_q == STREAK_CAP);

  // Data wins unless a waiting fetch has already been passed over STREAK_MAX times.
  assign grant_data  = data_elig & ~(fetch_elig & streak_at_cap);
  assign grant_fetch = fetch_elig & ~grant_data;

  // A fetch is discarded if flush was seen at any earlier edge of the access or at the completion edge.
  assign fetch_dead = killed_q | flush;

  // The load/store stage stalls until its own completion pulse.
  assign stall_mem = dm_req & ~dm_ready;

  // Next-state decode and datapath updates for the arbiter sequencer.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    killed_d    = killed_q;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = ACCESS;
          owner_d     = OWN_DATA;
          cnt_d       = LAT_INIT;
          killed_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // Only data grants that pass over a waiting fetch lengthen the streak.
          if (fetch_elig) begin
            streak_d = streak_at_cap ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (grant_fetch) begin
          state_d     = ACCESS;
          owner_d     = OWN_FETCH;
          cnt_d       = LAT_INIT;
          killed_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end

      ACCESS: begin
        if ((owner_q == OWN_FETCH) && flush) begin
          killed_d = 1'b1;
        end

        if (cnt_q == LAT_LAST) begin
          // Last access cycle: mem_rdata is valid now, so hand it to the owner.
          state_d  = IDLE;
          cnt_d    = '0;
          killed_d = 1'b0;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            dm_ready_d = 1'b1;
            if (!mem_we) begin
              dm_rdata_d = mem_rdata;
            end
          end else if (!fetch_dead) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - LAT_LAST;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered outputs. Reset aborts any access without a ready pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      cnt_q     <= '0;
      streak_q  <= '0;
      killed_q  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      killed_q  <= killed_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_ready  <= if_ready_d;
      dm_ready  <= dm_ready_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model tracks
// grants by edge number and predicts every output. Directed scenarios add
// literal expectations on latency, data, and grant order.
module tb_mem_port_arbiter;

  localparam int AW         = 8;
  localparam int DW         = 16;
  localparam int MEM_LAT    = 2;
  localparam int STREAK_MAX = 3;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          flush    = 1'b0;
  logic          halt     = 1'b0;
  logic          if_req   = 1'b0;
  logic [AW-1:0] if_addr  = '0;
  logic          dm_req   = 1'b0;
  logic          dm_we    = 1'b0;
  logic [AW-1:0] dm_addr  = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          stall_mem;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_pass  = 0;

  // Output counters for the directed scenarios.
  int n_en     = 0;
  int n_stall  = 0;
  int n_if_rdy = 0;
  int n_dm_rdy = 0;

  // Model state.
  bit            m_busy    = 1'b0;
  bit            m_data    = 1'b0;
  bit            m_we      = 1'b0;
  bit            m_killed  = 1'b0;
  int            m_edge    = 0;
  int            m_grant_at = 0;
  int            m_streak  = 0;
  logic [AW-1:0] m_addr    = '0;
  logic          e_mem_en    = 1'b0;
  logic          e_mem_we    = 1'b0;
  logic [AW-1:0] e_mem_addr  = '0;
  logic [DW-1:0] e_mem_wdata = '0;
  logic          e_if_ready  = 1'b0;
  logic          e_dm_ready  = 1'b0;
  logic [DW-1:0] e_if_rdata  = '0;
  logic [DW-1:0] e_dm_rdata  = '0;
  string         grant_log   = "";

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: combinational read while enabled, write on the clock edge.
  assign mem_rdata = mem_en ? mem[mem_addr] : 16'hDEAD;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\", expected \"%s\" at %0t", name, act, exp, $time);
  endtask

  // Model: a grant at edge g occupies the memory until edge g+MEM_LAT, then that owner gets ready.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_killed = 0; m_streak = 0;
      e_mem_en = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_ready = 0; e_dm_ready = 0; e_if_rdata = '0; e_dm_rdata = '0;
    end else begin
      bit f_el;
      bit take_d;
      m_edge++;
      e_if_ready = 0;
      e_dm_ready = 0;
      if (m_busy) begin
        if (!m_data && flush) m_killed = 1;
        if (m_edge - m_grant_at == MEM_LAT) begin
          m_busy = 0; e_mem_en = 0; e_mem_we = 0;
          if (m_data) begin
            e_dm_ready = 1;
            if (!m_we) e_dm_rdata = mem[m_addr];
          end else if (!m_killed) begin
            e_if_ready = 1;
            e_if_rdata = mem[m_addr];
          end
        end
      end else begin
        f_el   = if_req && !halt && !flush;
        take_d = dm_req && !(f_el && m_streak == STREAK_MAX);
        if (take_d || f_el) begin
          m_busy = 1; m_grant_at = m_edge; m_killed = 0; m_data = take_d;
          m_we   = take_d ? dm_we : 1'b0;
          m_addr = take_d ? dm_addr : if_addr;
          e_mem_en = 1; e_mem_we = m_we; e_mem_addr = m_addr;
          e_mem_wdata = take_d ? dm_wdata : '0;
          if (take_d) m_streak = f_el ? ((m_streak < STREAK_MAX) ? m_streak + 1 : STREAK_MAX) : 0;
          else        m_streak = 0;
          grant_log = {grant_log, take_d ? "D" : "F"};
        end
      end
    end
  end

  // Compare the DUT with the model every cycle outside reset, and count output activity.
  initial forever begin
    @(negedge clk);
    if (mem_en)    n_en++;
    if (stall_mem) n_stall++;
    if (if_ready)  n_if_rdy++;
    if (dm_ready)  n_dm_rdy++;
    if (!reset) begin
      check("mem_en",    32'(mem_en),    32'(e_mem_en));
      check("mem_we",    32'(mem_we),    32'(e_mem_we));
      check("mem_addr",  32'(mem_addr),  32'(e_mem_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
      check("if_ready",  32'(if_ready),  32'(e_if_ready));
      check("dm_ready",  32'(dm_ready),  32'(e_dm_ready));
      check("if_rdata",  32'(if_rdata),  32'(e_if_rdata));
      check("dm_rdata",  32'(dm_rdata),  32'(e_dm_rdata));
      check("stall_mem", 32'(stall_mem), 32'(dm_req & ~e_dm_ready));
    end
  end

  task automatic wait_dm(input int limit, output int n);
    bit found = 0;
    n = 0;
    while (n < limit && !found) begin
      @(negedge clk);
      n++;
      if (dm_ready) found = 1;
    end
    check("dm_ready within bound", 32'(found), 'h1);
  endtask

  task automatic wait_if(input int limit, output int n);
    bit found = 0;
    n = 0;
    while (n < limit && !found) begin
      @(negedge clk);
      n++;
      if (if_ready) found = 1;
    end
    check("if_ready within bound", 32'(found), 'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hA000 | 16'(i);
    mem[8'h10] = 16'hBEEF;

    // Reset state.
    #2;
    check("reset mem_en",    32'(mem_en),    'h0);
    check("reset mem_we",    32'(mem_we),    'h0);
    check("reset mem_addr",  32'(mem_addr),  'h0);
    check("reset mem_wdata", 32'(mem_wdata), 'h0);
    check("reset if_ready",  32'(if_ready),  'h0);
    check("reset dm_ready",  32'(dm_ready),  'h0);
    check("reset if_rdata",  32'(if_rdata),  'h0);
    check("reset dm_rdata",  32'(dm_rdata),  'h0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Single load from 0x10.
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 8'h10; n_en = 0; n_stall = 0;
    wait_dm(20, n);
    check("load latency", 32'(n), 32'(MEM_LAT + 2));
    check("load data", 32'(dm_rdata), 'hBEEF);
    check("load mem_en cycles", 32'(n_en), 32'(MEM_LAT));
    check("load stall cycles", 32'(n_stall), 32'(MEM_LAT + 1));
    #1 dm_req = 0;

    // Simultaneous fetch and store: data goes first, then the fetch.
    @(posedge clk); #1;
    grant_log = "";
    if_req = 1; if_addr = 8'h04;
    dm_req = 1; dm_we = 1; dm_addr = 8'h20; dm_wdata = 16'h1234;
    wait_dm(20, n);
    check("store written", 32'(mem[8'h20]), 'h1234);
    check_str("store first", grant_log, "D");
    #1 dm_req = 0; dm_we = 0;
    wait_if(20, n);
    check("fetch after store latency", 32'(n), 32'(MEM_LAT + 1));
    check("fetch data", 32'(if_rdata), 'hA004);
    check_str("store then fetch", grant_log, "DF");
    #1 if_req = 0;

    // Anti-starvation with both requests held.
    @(posedge clk); #1;
    grant_log = "";
    if_req = 1; if_addr = 8'h08;
    dm_req = 1; dm_we = 0; dm_addr = 8'h30;
    n = 0;
    while (grant_log.len() < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_str("starvation order", grant_log, "DDDFDDDF");
    #1 dm_req = 0;
    wait_if(20, n);
    check("starved fetch data", 32'(if_rdata), 'hA008);
    #1 if_req = 0;

    // Flush at the edge after a fetch grant.
    @(posedge clk); #1;
    if_req = 1; if_addr = 8'h0C; n_if_rdy = 0; n_en = 0;
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0; if_req = 0;
    repeat (4) @(posedge clk);
    #1;
    check("flushed no if_ready", 32'(n_if_rdy), 'h0);
    check("flushed if_rdata held", 32'(if_rdata), 'hA008);
    check("flushed access cycles", 32'(n_en), 32'(MEM_LAT));
    if_req = 1; if_addr = 8'h0E;
    wait_if(20, n);
    check("fetch after flush", 32'(if_rdata), 'hA00E);
    #1 if_req = 0;

    // Halt blocks fetch grants but data is still served.
    @(posedge clk); #1;
    halt = 1; if_req = 1; if_addr = 8'h06; n_en = 0; grant_log = "";
    repeat (10) @(posedge clk);
    #1;
    check("halt no mem_en", 32'(n_en), 'h0);
    check_str("halt no grant", grant_log, "");
    dm_req = 1; dm_we = 0; dm_addr = 8'h12;
    wait_dm(20, n);
    check("load during halt", 32'(dm_rdata), 'hA012);
    #1 dm_req = 0;
    @(posedge clk); #1;
    check_str("halt only data", grant_log, "D");
    halt = 0;
    @(posedge clk);
    @(negedge clk);
    check("fetch granted after halt", 32'(mem_en), 'h1);
    check("fetch addr after halt", 32'(mem_addr), 'h06);
    wait_if(20, n);
    check("fetch data after halt", 32'(if_rdata), 'hA006);
    #1 if_req = 0;

    // Reset in the middle of a load.
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 8'h14;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; dm_req = 0; n_dm_rdy = 0;
    #1;
    check("abort mem_en",   32'(mem_en),   'h0);
    check("abort mem_addr", 32'(mem_addr), 'h0);
    check("abort dm_ready", 32'(dm_ready), 'h0);
    check("abort dm_rdata", 32'(dm_rdata), 'h0);
    check("abort if_rdata", 32'(if_rdata), 'h0);
    repeat (3) @(posedge clk);
    #1;
    check("abort no dm_ready", 32'(n_dm_rdy), 'h0);
    reset = 0;
    @(posedge clk); #1;
    dm_req = 1; dm_addr = 8'h14; n_en = 0;
    wait_dm(20, n);
    check("post-reset latency", 32'(n), 32'(MEM_LAT + 2));
    check("post-reset data", 32'(dm_rdata), 'hA014);
    check("post-reset mem_en cycles", 32'(n_en), 32'(MEM_LAT));
    #1 dm_req = 0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
